// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register-file write arbiter.
//   REG_ADDR_W : width of a register index
//   DATA_W     : width of register data and PC values
//   NUM_REGS   : number of architectural registers (entry 0 is hardwired zero)
//   wr_req_t   : one write request {rd, data, pc}; it is used for the WB source,
//                the LL source and the LL skid-buffer entries.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
    logic [DATA_W-1:0]     pc;
  } wr_req_t;

endpackage

// File: rtl/regfile_write_arbiter_wr_fifo.sv
// wr_fifo: small synchronous circular FIFO of wr_req_t, used as the skid buffer
// for long-latency results waiting for the register-file write port.
// Ports:
//   i_clk, i_rst     : clock (rising edge), synchronous active-high reset
//   i_push, i_push_data : write one entry (ignored when full)
//   i_pop            : drop the head entry (ignored when empty)
//   o_head           : current head entry (valid when !o_empty)
//   o_full, o_empty  : occupancy flags
module wr_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    i_clk,
  input  logic    i_rst,
  input  logic    i_push,
  input  wr_req_t i_push_data,
  input  logic    i_pop,
  output wr_req_t o_head,
  output logic    o_full,
  output logic    o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  wr_req_t          r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == CNT_FULL);
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register file's single write port between
// the in-order writeback stage (WB) and the long-latency unit (LL), and keeps a
// busy scoreboard of registers awaiting an LL result for the decode stall.
// Ports:
//   clock, reset                   : rising-edge clock, synchronous active-high reset
//   wb_valid/wb_rd/wb_data/wb_pc   : WB write request (no back-pressure except wb_stall)
//   wb_stall                       : holds WB for one cycle so a starved LL head drains
//   ll_valid/ll_ready/ll_rd/...    : LL result stream into the skid buffer
//   issue_valid/issue_rd           : LL op issue, marks its destination busy
//   dec_rs/dec_rt/dec_rd/dec_stall : decode hazard query against the scoreboard
//   wr_en/wr_rd/wr_data/wr_pc      : registered write-port outputs
//   busy                           : scoreboard vector, bit 0 always 0
//
// LL handshake: a result transfers in every cycle where ll_valid and ll_ready are
// both high; ll_ready depends only on registered FIFO state (not full), so the
// producer may hold ll_valid and its fields stable until it sees ll_ready.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic [31:0] wb_pc,
  output logic        wb_stall,
  input  logic        ll_valid,
  output logic        ll_ready,
  input  logic [4:0]  ll_rd,
  input  logic [31:0] ll_data,
  input  logic [31:0] ll_pc,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  dec_rs,
  input  logic [4:0]  dec_rt,
  input  logic [4:0]  dec_rd,
  output logic        dec_stall,
  output logic        wr_en,
  output logic [4:0]  wr_rd,
  output logic [31:0] wr_data,
  output logic [31:0] wr_pc,
  output logic [31:0] busy
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  logic                r_wr_en;
  wr_req_t             r_wr_req;
  logic                r_wb_stall;
  logic [STARVE_W-1:0] r_starve;
  logic [31:0]         r_busy;

  logic                w_wb_claim;
  logic                w_ll_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  wr_req_t             w_head;
  wr_req_t             w_wb_req;
  wr_req_t             w_ll_req;
  logic [STARVE_W-1:0] w_starve_nxt;
  logic [31:0]         w_busy_nxt;

  assign w_wb_req = '{rd: wb_rd, data: wb_data, pc: wb_pc};
  assign w_ll_req = '{rd: ll_rd, data: ll_data, pc: ll_pc};

  // Writes to $0 are architectural no-ops: they neither claim the port nor
  // occupy the buffer (an LL result for $0 is accepted and dropped).
  assign w_wb_claim = wb_valid && !r_wb_stall && (wb_rd != '0);
  assign ll_ready   = !w_full;
  assign w_ll_push  = ll_valid && !w_full && (ll_rd != '0);
  // WB has priority; the LL head only gets the port in a cycle WB leaves free.
  assign w_pop      = !w_wb_claim && !w_empty;

  wr_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_clk      (clock),
    .i_rst      (reset),
    .i_push     (w_ll_push),
    .i_push_data(w_ll_req),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  // Starve counter: cycles the head has waited. Reaching the limit raises
  // wb_stall for the next cycle, during which WB cannot claim, so the head pops
  // and the counter returns to 0 -- the stall is therefore a single-cycle pulse.
  always_comb begin
    w_starve_nxt = r_starve;
    if (w_empty || w_pop) begin
      w_starve_nxt = '0;
    end else if (r_starve != STARVE_MAX) begin
      w_starve_nxt = r_starve + STARVE_W'(1);
    end
  end

  // Scoreboard: clear on pop first, then set, so a same-cycle issue to the
  // register being drained leaves it busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_pop) begin
      w_busy_nxt[w_head.rd] = 1'b0;
    end
    if (issue_valid && (issue_rd != '0)) begin
      w_busy_nxt[issue_rd] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_en    <= 1'b0;
      r_wr_req   <= '0;
      r_wb_stall <= 1'b0;
      r_starve   <= '0;
      r_busy     <= '0;
    end else begin
      r_wr_en    <= w_wb_claim || w_pop;
      if (w_wb_claim) begin
        r_wr_req <= w_wb_req;
      end else if (w_pop) begin
        r_wr_req <= w_head;
      end
      r_wb_stall <= (w_starve_nxt == STARVE_MAX);
      r_starve   <= w_starve_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  // busy[0] is never set, so $0 never contributes to the hazard.
  assign dec_stall = r_busy[dec_rs] | r_busy[dec_rt] | r_busy[dec_rd];

  assign wb_stall = r_wb_stall;
  assign wr_en    = r_wr_en;
  assign wr_rd    = r_wr_req.rd;
  assign wr_data  = r_wr_req.data;
  assign wr_pc    = r_wr_req.pc;
  assign busy     = r_busy;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: a cycle table of inputs with
// hand-computed expected outputs, plus hand-written reset and set/clear sequences.
module tb_regfile_write_arbiter;

  logic        clock;
  logic        reset;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] wb_pc;
  logic        wb_stall;
  logic        ll_valid;
  logic        ll_ready;
  logic [4:0]  ll_rd;
  logic [31:0] ll_data;
  logic [31:0] ll_pc;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  dec_rs;
  logic [4:0]  dec_rt;
  logic [4:0]  dec_rd;
  logic        dec_stall;
  logic        wr_en;
  logic [4:0]  wr_rd;
  logic [31:0] wr_data;
  logic [31:0] wr_pc;
  logic [31:0] busy;

  regfile_write_arbiter #(
    .FIFO_DEPTH  (2),
    .STARVE_LIMIT(4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .wb_pc      (wb_pc),
    .wb_stall   (wb_stall),
    .ll_valid   (ll_valid),
    .ll_ready   (ll_ready),
    .ll_rd      (ll_rd),
    .ll_data    (ll_data),
    .ll_pc      (ll_pc),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .dec_rs     (dec_rs),
    .dec_rt     (dec_rt),
    .dec_rd     (dec_rd),
    .dec_stall  (dec_stall),
    .wr_en      (wr_en),
    .wr_rd      (wr_rd),
    .wr_data    (wr_data),
    .wr_pc      (wr_pc),
    .busy       (busy)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- bookkeeping ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cur     = -1;
  logic        allow_reissue = 1'b0;
  logic [31:0] exp_q[$];

  // One cycle: inputs + comb expectations (before the edge) + registered
  // expectations (after the edge). All fields 32 bits wide for easy literals.
  typedef struct {
    logic [31:0] wbv, wbrd, wbd, wbpc;
    logic [31:0] llv, llrd, lld, llpc;
    logic [31:0] iv, ird;
    logic [31:0] rs, rt, rd;
    logic [31:0] e_llr, e_dst;
    logic [31:0] e_wen, e_wrd, e_wdata, e_wpc, e_stall, e_busy;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got %h, required %h", name, cur, act, exp);
    end
  endtask

  task automatic drive_idle();
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0; wb_pc = '0;
    ll_valid = 1'b0; ll_rd = '0; ll_data = '0; ll_pc = '0;
    issue_valid = 1'b0; issue_rd = '0;
    dec_rs = '0; dec_rt = '0; dec_rd = '0;
  endtask

  task automatic drive_vec(input vec_t v);
    wb_valid = v.wbv[0]; wb_rd = v.wbrd[4:0]; wb_data = v.wbd; wb_pc = v.wbpc;
    ll_valid = v.llv[0]; ll_rd = v.llrd[4:0]; ll_data = v.lld; ll_pc = v.llpc;
    issue_valid = v.iv[0]; issue_rd = v.ird[4:0];
    dec_rs = v.rs[4:0]; dec_rt = v.rt[4:0]; dec_rd = v.rd[4:0];
  endtask

  // Advance one clock. Before the edge: issuing to a register still busy is an
  // upstream protocol error. After the edge: every LL write (pc 0x5xxx) must
  // match the oldest accepted LL result.
  task automatic tick();
    logic [31:0] e;
    if (!reset && issue_valid && issue_rd != 5'd0 && busy[issue_rd] && !allow_reissue) begin
      n_tests++;
      n_fail++;
      $display("FAIL issue_to_busy (step %0d): rd %0d busy=%h, required bit clear", cur, issue_rd, busy);
    end
    @(posedge clock);
    #1;
    if (wr_en && wr_pc[31:12] == 20'h00005) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL ll_order (step %0d): unexpected LL write data %h pc %h, required none", cur, wr_data, wr_pc);
      end else begin
        e = exp_q.pop_front();
        if (wr_data !== e) begin
          n_fail++;
          $display("FAIL ll_order (step %0d): got data %h, required %h", cur, wr_data, e);
        end
      end
    end
  endtask

  initial begin
    // wbv wbrd wbd wbpc | llv llrd lld llpc | iv ird | rs rt rd | e_llr e_dst | e_wen e_wrd e_wdata e_wpc e_stall e_busy
    // WB only, then WB to $0
    vecs[0]  = '{1, 5, 'hDEADBEEF, 'h3000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 5, 'hDEADBEEF, 'h3000, 0, 0};
    vecs[1]  = '{1, 0, 'h12345678, 'h3004, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5, 'hDEADBEEF, 'h3000, 0, 0};
    // contention: issue rd8, LL rd8 arrives while WB writes every cycle
    vecs[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 8, 0, 0, 0, 1, 0, 0, 5, 'hDEADBEEF, 'h3000, 0, 'h100};
    vecs[3]  = '{1, 1, 'hA1, 'h3010, 1, 8, 'h11, 'h5000, 0, 0, 8, 0, 0, 1, 1, 1, 1, 'hA1, 'h3010, 0, 'h100};
    vecs[4]  = '{1, 2, 'hB2, 'h3014, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 2, 'hB2, 'h3014, 0, 'h100};
    vecs[5]  = '{1, 3, 'hC3, 'h3018, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 3, 'hC3, 'h3018, 0, 'h100};
    vecs[6]  = '{1, 4, 'hD4, 'h301C, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 4, 'hD4, 'h301C, 0, 'h100};
    vecs[7]  = '{1, 6, 'hE6, 'h3020, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 6, 'hE6, 'h3020, 1, 'h100};
    vecs[8]  = '{1, 7, 'hF7, 'h3024, 0, 0, 0, 0, 0, 0, 8, 0, 0, 1, 1, 1, 8, 'h11, 'h5000, 0, 0};
    vecs[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8, 0, 0, 1, 0, 0, 8, 'h11, 'h5000, 0, 0};
    // full FIFO: two LL pushes under continuous WB, third attempt refused
    vecs[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 10, 0, 0, 0, 1, 0, 0, 8, 'h11, 'h5000, 0, 'h400};
    vecs[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 11, 0, 0, 0, 1, 0, 0, 8, 'h11, 'h5000, 0, 'hC00};
    vecs[12] = '{1, 1, 'h1, 'h3100, 1, 10, 'hAAAA, 'h5010, 0, 0, 0, 0, 0, 1, 0, 1, 1, 'h1, 'h3100, 0, 'hC00};
    vecs[13] = '{1, 2, 'h2, 'h3104, 1, 11, 'hBBBB, 'h5014, 0, 0, 0, 0, 0, 1, 0, 1, 2, 'h2, 'h3104, 0, 'hC00};
    vecs[14] = '{1, 3, 'h3, 'h3108, 1, 12, 'hCCCC, 'h5018, 0, 0, 0, 0, 0, 0, 0, 1, 3, 'h3, 'h3108, 0, 'hC00};
    vecs[15] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 10, 'hAAAA, 'h5010, 0, 'h800};
    vecs[16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 11, 'hBBBB, 'h5014, 0, 0};
    vecs[17] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 11, 'hBBBB, 'h5014, 0, 0};
    // hazards on rd9 via rs, rt, rd until its pop
    vecs[18] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 1, 0, 0, 11, 'hBBBB, 'h5014, 0, 'h200};
    vecs[19] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 0, 1, 1, 0, 11, 'hBBBB, 'h5014, 0, 'h200};
    vecs[20] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 1, 1, 0, 11, 'hBBBB, 'h5014, 0, 'h200};
    vecs[21] = '{0, 0, 0, 0, 1, 9, 'h99, 'h5020, 0, 0, 0, 0, 9, 1, 1, 0, 11, 'hBBBB, 'h5014, 0, 'h200};
    vecs[22] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 1, 1, 1, 9, 'h99, 'h5020, 0, 0};
    vecs[23] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 9, 9, 1, 0, 0, 9, 'h99, 'h5020, 0, 0};
    // $0: issue never marks busy, LL result accepted and dropped
    vecs[24] = '{0, 0, 0, 0, 1, 0, 'h77, 'h5028, 1, 0, 0, 0, 0, 1, 0, 0, 9, 'h99, 'h5020, 0, 0};
    vecs[25] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 9, 'h99, 'h5020, 0, 0};

    // ---------------- reset ----------------
    drive_idle();
    reset = 1'b1;
    tick();
    tick();
    chk("rst_wr_en",   32'(wr_en), 0);
    chk("rst_wr_rd",   32'(wr_rd), 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_wr_pc",   wr_pc, 0);
    chk("rst_wb_stall", 32'(wb_stall), 0);
    chk("rst_busy",    busy, 0);
    chk("rst_ll_ready", 32'(ll_ready), 1);
    reset = 1'b0;

    // ---------------- reset mid-operation ----------------
    cur = 100;
    issue_valid = 1'b1; issue_rd = 5'd4; tick();
    issue_rd = 5'd5; tick();
    issue_valid = 1'b0;
    wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'h1; wb_pc = 32'h3200;
    ll_valid = 1'b1; ll_rd = 5'd4; ll_data = 32'h44; ll_pc = 32'h5100; tick();
    wb_rd = 5'd2; wb_pc = 32'h3204;
    ll_rd = 5'd5; ll_data = 32'h55; ll_pc = 32'h5104; tick();
    ll_valid = 1'b0; wb_rd = 5'd3; wb_pc = 32'h3208;
    #1;
    chk("midrst_full", 32'(ll_ready), 0);
    chk("midrst_busy_pre", busy, 32'h0000_0030);
    tick();
    drive_idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_wr_en", 32'(wr_en), 0);
    chk("midrst_ll_ready", 32'(ll_ready), 1);
    chk("midrst_wb_stall", 32'(wb_stall), 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("midrst_no_pop", 32'(wr_en), 0);
    end

    // ---------------- table ----------------
    for (int i = 0; i < NV; i++) begin
      cur = i;
      drive_vec(vecs[i]);
      #1;
      chk("ll_ready", 32'(ll_ready), vecs[i].e_llr);
      chk("dec_stall", 32'(dec_stall), vecs[i].e_dst);
      if (vecs[i].llv[0] && vecs[i].e_llr[0] && vecs[i].llrd[4:0] != 5'd0)
        exp_q.push_back(vecs[i].lld);
      tick();
      chk("wr_en",    32'(wr_en), vecs[i].e_wen);
      chk("wr_rd",    32'(wr_rd), vecs[i].e_wrd);
      chk("wr_data",  wr_data, vecs[i].e_wdata);
      chk("wr_pc",    wr_pc, vecs[i].e_wpc);
      chk("wb_stall", 32'(wb_stall), vecs[i].e_stall);
      chk("busy",     busy, vecs[i].e_busy);
    end

    // ---------------- same-cycle set and clear of rd9 ----------------
    cur = 200;
    drive_idle();
    issue_valid = 1'b1; issue_rd = 5'd9; tick();
    chk("coll_busy_set", busy, 32'h200);
    issue_valid = 1'b0;
    ll_valid = 1'b1; ll_rd = 5'd9; ll_data = 32'h9A; ll_pc = 32'h5030;
    #1;
    chk("coll_ll_ready", 32'(ll_ready), 1);
    exp_q.push_back(32'h9A);
    tick();
    ll_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd9; allow_reissue = 1'b1;
    tick();
    chk("coll_wr_en", 32'(wr_en), 1);
    chk("coll_wr_rd", 32'(wr_rd), 9);
    chk("coll_busy_kept", busy, 32'h200);
    allow_reissue = 1'b0;
    issue_valid = 1'b0;
    ll_valid = 1'b1; ll_rd = 5'd9; ll_data = 32'h9B; ll_pc = 32'h5034;
    exp_q.push_back(32'h9B);
    tick();
    drive_idle();
    tick();
    chk("coll2_wr_data", wr_data, 32'h9B);
    chk("coll2_busy", busy, 0);
    tick();
    chk("ll_queue_drained", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between two sources: the in-order pipeline writeback (WB) and the long-latency multiply/divide/late-load unit (LL).
- Keeps a 32-bit busy scoreboard of registers with an outstanding LL result, and raises a decode stall on RAW/WAW hazards against them.
- Sits between the WB stage and the general purpose register file.
- Write-port outputs are registered on the rising edge, so they are stable for the register file's falling-edge write.

Parameters:
- FIFO_DEPTH, 2: entries in the LL result skid buffer (power of two, ≥2).
- STARVE_LIMIT, 4: cycles an LL head may wait before WB is forced to stall.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- wb_valid  in  1  pipeline writeback request this cycle (no ready; must be honoured unless wb_stall was high).
- wb_rd  in  5  WB destination register.
- wb_data  in  32  WB write data.
- wb_pc  in  32  PC of the WB instruction.
- wb_stall  out  1  forces the pipeline to hold WB for one cycle (starvation relief).
- ll_valid  in  1  LL result valid.
- ll_ready  out  1  LL result accepted (= FIFO not full).
- ll_rd  in  5  LL destination register.
- ll_data  in  32  LL result data.
- ll_pc  in  32  PC of the LL instruction.
- issue_valid  in  1  LL op issued this cycle.
- issue_rd  in  5  LL op destination register.
- dec_rs  in  5  decode source register rs.
- dec_rt  in  5  decode source register rt.
- dec_rd  in  5  decode destination register.
- dec_stall  out  1  combinational hazard stall to decode.
- wr_en  out  1  register file write enable.
- wr_rd  out  5  register file write address.
- wr_data  out  32  register file write data.
- wr_pc  out  32  PC reported with the write.
- busy  out  32  scoreboard vector; bit 0 is always 0.

Behaviour:
- Reset: wr_en=0, wr_rd=0, wr_data=0, wr_pc=0, wb_stall=0, busy=0, FIFO empty, starve counter=0. This applies mid-operation: in-flight LL entries are discarded and ll_ready=1 in the cycle after reset.
- Port claim: WB claims the port when wb_valid && !wb_stall && wb_rd≠0. Writes to $0 never claim the port.
- Port grant:
  - WB claim → wr_* = WB fields on the next edge (latency 1).
  - Otherwise, FIFO non-empty → pop the head and register its fields (latency 1 from the grant).
  - Otherwise → wr_en=0 next cycle; wr_rd/data/pc hold.
- LL push: occurs when ll_valid && ll_ready.
  - ll_rd=0 is accepted and dropped, never stored.
  - An LL value can reach the write port no earlier than 2 cycles after ll_valid (push then pop).
- FIFO: circular buffer with pointers wrapping modulo FIFO_DEPTH.
  - Simultaneous push and pop while full is forbidden, since ll_ready=0 when full.
  - Simultaneous push and pop otherwise keeps the count unchanged.
  - Occupancy never exceeds FIFO_DEPTH.
- Starve counter:
  - Increments each cycle the FIFO is non-empty and the head is not popped.
  - Resets to 0 on a pop or when the FIFO is empty.
  - When it equals STARVE_LIMIT, wb_stall=1 for exactly one cycle, which guarantees a pop. wb_stall is registered.
- Scoreboard set: set busy[issue_rd] on issue_valid && issue_rd≠0.
- Scoreboard clear:
  - Clear busy[r] when an LL entry for r is popped to the port.
  - Same-cycle set and clear of the same r: set wins.
- dec_stall = busy[dec_rs] | busy[dec_rt] | busy[dec_rd]. Index 0 contributes 0.
  - Covers RAW and WAW, so a later WB write can never be overwritten by an older LL result.
- Ordering: one WB write and one LL pop never occur in the same cycle. Port utilisation is at most 1 write per cycle.
- Illegal case: issue_valid to an already-busy register is an upstream protocol error.
  - Bench asserts on it.
  - The RTL leaves the bit set.

Decomposition:
- Shared package regfile_pkg holds:
  - REG_ADDR_W=5, DATA_W=32, NUM_REGS=32.
  - Packed struct wr_req_t {rd, data, pc}, used for WB, LL and FIFO entries.
- One natural sub-module: wr_fifo, a parameterised sync FIFO of wr_req_t with push/pop/full/empty.
- Arbitration, starve counter and scoreboard stay in the top module.

Test Plan:
1. Reset mid-op: FIFO holds 2 entries, busy=0x0000_0030, reset asserted 1 cycle → busy=0, wr_en=0, ll_ready=1 next cycle, and no pop appears afterwards.
2. WB only: wb_valid, rd=5, data=0xDEADBEEF, pc=0x3000 → next edge wr_en=1, wr_rd=5, wr_data=0xDEADBEEF, wr_pc=0x3000. The same request with rd=0 → wr_en=0.
3. Contention: issue rd=8, then ll_valid rd=8 data=0x11 while wb_valid runs every cycle.
   - Required: the LL write is held; wb_stall pulses once after 4 waiting cycles.
   - Required: the following cycle gives wr_rd=8, wr_data=0x11 and busy[8] clears.
4. Full FIFO: two LL pushes while WB runs continuously → ll_ready=0 on the third attempt. The entries then drain in order A,B when WB idles.
5. Hazards and set/clear collision:
   - issue rd=9, then dec_rs=9 → dec_stall=1 until the rd=9 pop; dec_rd=9 likewise stalls.
   - Same-cycle issue rd=9 and pop of rd=9 → busy[9] stays 1.
